// File: rtl/pad_ddr_tx.sv
// DDR transmit serializer feeding an iCE40 SB_IO in DDR output mode.
// Words are accepted over valid/ready and shifted out LSB-first, two bits per clock.
module pad_ddr_tx #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             d_out_0,
  output logic             d_out_1,
  output logic             output_enable,
  output logic             last_pair
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAIRS - 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
      $error("pad_ddr_tx: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_d0, w_d0_next;
  logic             r_d1, w_d1_next;
  logic             r_oe, w_oe_next;
  logic             w_final;
  logic             w_ready;
  logic             w_accept;

  // Ready during the final pair lets the next word follow with no idle cycle.
  assign w_final  = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);
  assign w_ready  = (r_state == S_IDLE) || w_final;
  assign w_accept = data_valid && w_ready;

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_d0_next    = r_d0;
    w_d1_next    = r_d1;
    w_oe_next    = r_oe;
    if (w_accept) begin
      w_d0_next    = data_in[0];
      w_d1_next    = data_in[1];
      w_oe_next    = 1'b1;
      w_shift_next = data_in >> 2;
      w_cnt_next   = '0;
      w_state_next = S_SHIFT;
    end else if (r_state == S_SHIFT) begin
      if (w_final) begin
        w_state_next = S_IDLE;
        w_oe_next    = 1'b0;
        w_d0_next    = IDLE_LEVEL;
        w_d1_next    = IDLE_LEVEL;
        w_shift_next = '0;
        w_cnt_next   = '0;
      end else begin
        w_d0_next    = r_shift[0];
        w_d1_next    = r_shift[1];
        w_shift_next = r_shift >> 2;
        w_cnt_next   = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_d0    <= IDLE_LEVEL;
      r_d1    <= IDLE_LEVEL;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_d0    <= w_d0_next;
      r_d1    <= w_d1_next;
      r_oe    <= w_oe_next;
    end
  end

  assign data_ready    = w_ready;
  assign d_out_0       = r_d0;
  assign d_out_1       = r_d1;
  assign output_enable = r_oe;
  assign last_pair     = w_final;

endmodule

// File: tb/tb_pad_ddr_tx.sv
// Scoreboard bench for pad_ddr_tx: an 8-bit/idle-0 instance and a 2-bit/idle-1 instance.
module tb_pad_ddr_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_din;
  logic       a_valid, a_ready, a_d0, a_d1, a_oe, a_last;
  logic [1:0] b_din;
  logic       b_valid, b_ready, b_d0, b_d1, b_oe, b_last;

  int checks = 0;
  int errors = 0;
  int a_rem  = 0;
  int b_rem  = 0;
  int a_acc  = 0;
  bit mon_en = 1'b0;

  logic [2:0] qa [$];
  logic [2:0] qb [$];
  logic [1:0] obs_a [$];
  logic [1:0] obs_b [$];

  always #5 clk = ~clk;

  pad_ddr_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .reset(rst), .data_in(a_din), .data_valid(a_valid),
    .data_ready(a_ready), .d_out_0(a_d0), .d_out_1(a_d1),
    .output_enable(a_oe), .last_pair(a_last)
  );

  pad_ddr_tx #(.WIDTH(2), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .reset(rst), .data_in(b_din), .data_valid(b_valid),
    .data_ready(b_ready), .d_out_0(b_d0), .d_out_1(b_d1),
    .output_enable(b_oe), .last_pair(b_last)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard for every pair on the pad.
  task automatic monitor();
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("a_ready", {3'b0, a_ready}, {3'b0, (a_rem <= 1)});
        if (a_oe === 1'b1) begin
          if (qa.size() == 0) chk("a_unexpected_oe", {3'b0, a_oe}, 4'h0);
          else begin
            e = qa.pop_front();
            chk("a_pair", {1'b0, a_d0, a_d1, a_last}, {1'b0, e});
            obs_a.push_back({a_d0, a_d1});
          end
        end else begin
          chk("a_idle", {a_oe, a_d0, a_d1, a_last}, 4'b0000);
          chk("a_gap", {3'b0, (qa.size() != 0)}, 4'h0);
        end
        chk("b_ready", {3'b0, b_ready}, {3'b0, (b_rem <= 1)});
        if (b_oe === 1'b1) begin
          if (qb.size() == 0) chk("b_unexpected_oe", {3'b0, b_oe}, 4'h0);
          else begin
            e = qb.pop_front();
            chk("b_pair", {1'b0, b_d0, b_d1, b_last}, {1'b0, e});
            obs_b.push_back({b_d0, b_d1});
          end
        end else begin
          chk("b_idle", {b_oe, b_d0, b_d1, b_last}, 4'b0110);
          chk("b_gap", {3'b0, (qb.size() != 0)}, 4'h0);
        end
      end
    end
  endtask

  // One clock of stimulus plus the reference model update at the same edge.
  task automatic step(input logic r, input logic av, input logic [7:0] ad,
                      input logic bv, input logic [1:0] bd);
    rst = r; a_valid = av; a_din = ad; b_valid = bv; b_din = bd;
    @(posedge clk);
    if (r) begin
      qa.delete(); qb.delete(); a_rem = 0; b_rem = 0;
    end else begin
      if (av && a_rem <= 1) begin
        a_rem = 4;
        a_acc++;
        for (int k = 0; k < 4; k++) qa.push_back({ad[2*k], ad[2*k+1], (k == 3)});
      end else if (a_rem > 0) a_rem--;
      if (bv && b_rem <= 1) begin
        b_rem = 1;
        qb.push_back({bd[0], bd[1], 1'b1});
      end else if (b_rem > 0) b_rem--;
    end
    #1;
  endtask

  logic [1:0] exp_ab [8] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
  logic [1:0] exp_b  [2] = '{2'b01, 2'b10};

  initial begin
    fork monitor(); join_none
    rst = 1'b1; a_valid = 1'b0; a_din = '0; b_valid = 1'b0; b_din = '0;
    #1;
    // Reset with valid high and all-ones data
    step(1'b1, 1'b1, 8'hFF, 1'b0, 2'b00);
    mon_en = 1'b1;
    step(1'b1, 1'b1, 8'hFF, 1'b0, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    $display("txn reset: released, a_ready=%0b a_oe=%0b", a_ready, a_oe);

    // Single word
    step(1'b0, 1'b1, 8'hA5, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    $display("txn single: word A5 sent");

    // Back-to-back A5 then 3C with valid held
    obs_a.delete();
    step(1'b0, 1'b1, 8'hA5, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h3C, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("ab_count", 4'(obs_a.size()), 4'd8);
    if (obs_a.size() == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("ab_pair%0d", i), {2'b0, obs_a[i]}, {2'b0, exp_ab[i]});
    $display("txn b2b: A5,3C observed %0d pairs", obs_a.size());

    // Reset during pair 2, then a clean 01
    step(1'b0, 1'b1, 8'hFF, 1'b0, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00);
    obs_a.delete();
    step(1'b0, 1'b1, 8'h01, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("rst_mid_count", 4'(obs_a.size()), 4'd4);
    if (obs_a.size() == 4) chk("rst_mid_pair0", {2'b0, obs_a[0]}, 4'b0010);
    $display("txn reset_mid: FF dropped, 01 resent");

    // Random stall with data changing every cycle
    a_acc = 0;
    for (int c = 0; c < 20000 && a_acc < 1000; c++)
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    if (a_acc < 1000) chk("stall_timeout", 4'h1, 4'h0);
    $display("txn stall: %0d words accepted", a_acc);

    // WIDTH=2, IDLE_LEVEL=1 streaming
    obs_b.delete();
    step(1'b0, 1'b0, 8'h00, 1'b1, 2'b10);
    step(1'b0, 1'b0, 8'h00, 1'b1, 2'b01);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("w2_count", 4'(obs_b.size()), 4'd2);
    if (obs_b.size() == 2)
      for (int i = 0; i < 2; i++) chk($sformatf("w2_pair%0d", i), {2'b0, obs_b[i]}, {2'b0, exp_b[i]});
    $display("txn w2: 10,01 streamed");

    chk("drain_a", 4'(qa.size()), 4'd0);
    chk("drain_b", 4'(qb.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
